// File: rtl/conv_pool_stream.sv
// Streaming conv/clamp/pool engine: fetches one 4x4 window per channel, convolves
// with a latched 3x3 kernel per channel, clamps to 8 bits and pools the 2x2 result.
module conv_pool_stream #(
  parameter int CHANNELS = 3,
  parameter int NUM_OUT  = 65025,
  parameter int ADDR_W   = 16,
  parameter int BIAS_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pool_mode,
  input  logic signed [BIAS_W-1:0]   bias,
  input  logic [CHANNELS*72-1:0]     kernel,
  input  logic [CHANNELS*128-1:0]    image,
  input  logic                       in_valid,
  output logic                       in_re,
  output logic [ADDR_W-1:0]          in_addr,
  input  logic                       out_ready,
  output logic                       out_we,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [7:0]                 y,
  output logic                       busy,
  output logic                       done
);

  // Wide enough for 72 products of 8-bit signed x 8-bit unsigned plus the bias.
  localparam int SUM_W = BIAS_W + 26;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_OUT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] CALC  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]                state;
  logic [ADDR_W-1:0]         counter;
  logic                      pool_mode_r;
  logic signed [BIAS_W-1:0]  bias_r;
  logic [CHANNELS*72-1:0]    kernel_r;
  logic [CHANNELS*128-1:0]   image_r;
  logic [7:0]                result;

  logic signed [SUM_W-1:0]   acc;
  logic signed [7:0]         coef;
  logic [7:0]                pix;
  logic [7:0]                clamped [4];
  logic [9:0]                sum;
  logic [7:0]                max_val;
  logic [7:0]                pooled;

  always_comb begin
    acc  = '0;
    coef = '0;
    pix  = '0;
    for (int n = 0; n < 4; n++) clamped[n] = '0;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        acc = SUM_W'(bias_r);
        for (int c = 0; c < CHANNELS; c++) begin
          for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
              coef = kernel_r[c*72 + (i*3 + j)*8 +: 8];
              pix  = image_r[c*128 + ((a + i)*4 + b + j)*8 +: 8];
              acc  = acc + SUM_W'(coef) * SUM_W'($signed({1'b0, pix}));
            end
          end
        end
        if (acc <= 0)
          clamped[a*2 + b] = 8'd0;
        else if (acc >= 255)
          clamped[a*2 + b] = 8'd255;
        else
          clamped[a*2 + b] = acc[7:0];
      end
    end
  end

  // Pooled clamped values are non-negative, so the shift is a floor divide.
  always_comb begin
    sum = {2'b00, clamped[0]} + {2'b00, clamped[1]} + {2'b00, clamped[2]} + {2'b00, clamped[3]};
    max_val = clamped[0];
    for (int n = 1; n < 4; n++) begin
      if (clamped[n] > max_val) max_val = clamped[n];
    end
    pooled = pool_mode_r ? max_val : 8'(sum >> 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      pool_mode_r <= 1'b0;
      bias_r      <= '0;
      kernel_r    <= '0;
      image_r     <= '0;
      result      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pool_mode_r <= pool_mode;
            bias_r      <= bias;
            kernel_r    <= kernel;
            counter     <= '0;
            state       <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          if (in_valid) begin
            image_r <= image;
            state   <= CALC;
          end
        end
        CALC: begin
          result <= pooled;
          state  <= WRITE;
        end
        WRITE: begin
          if (out_ready) begin
            if (counter == LAST) begin
              state <= DONE;
            end else begin
              counter <= counter + 1'b1;
              state   <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_re    = (state == FETCH);
  assign in_addr  = counter;
  assign out_we   = (state == WRITE);
  assign out_addr = counter;
  assign y        = result;
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_conv_pool_stream.sv
// Scoreboard bench for conv_pool_stream: a memory responder feeds windows,
// expected pixels are queued on delivery and retired on accepted writes.
module tb_conv_pool_stream;

  localparam int CH   = 3;
  localparam int NOUT = 4;
  localparam int AW   = 16;
  localparam int BW   = 12;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   pool_mode;
  logic signed [BW-1:0]   bias;
  logic [CH*72-1:0]       kernel;
  logic [CH*128-1:0]      image;
  logic                   in_valid;
  logic                   in_re;
  logic [AW-1:0]          in_addr;
  logic                   out_ready;
  logic                   out_we;
  logic [AW-1:0]          out_addr;
  logic [7:0]             y;
  logic                   busy;
  logic                   done;

  conv_pool_stream #(.CHANNELS(CH), .NUM_OUT(NOUT), .ADDR_W(AW), .BIAS_W(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .pool_mode(pool_mode), .bias(bias),
    .kernel(kernel), .image(image), .in_valid(in_valid), .in_re(in_re),
    .in_addr(in_addr), .out_ready(out_ready), .out_we(out_we), .out_addr(out_addr),
    .y(y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    y;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  logic [CH*72-1:0]  cfg_kernel;
  int                cfg_bias;
  logic              cfg_mode;
  logic [CH*128-1:0] img_tab [NOUT];
  int                delay_addr, delay_len, stall_addr, stall_len;

  bit active = 1'b0;
  bit pend;
  int pend_cnt, pend_addr;
  int exp_in_addr, writes, dones, stall_left;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] model(input logic [CH*128-1:0] img);
    int o, cl, s, mx;
    logic signed [7:0] ks;
    s = 0;
    mx = 0;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        o = cfg_bias;
        for (int c = 0; c < CH; c++)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              ks = cfg_kernel[c*72 + (i*3 + j)*8 +: 8];
              o += int'(ks) * int'(img[c*128 + ((a + i)*4 + b + j)*8 +: 8]);
            end
        cl = (o <= 0) ? 0 : ((o >= 255) ? 255 : o);
        s += cl;
        if (cl > mx) mx = cl;
      end
    end
    return cfg_mode ? 8'(mx) : 8'(s / 4);
  endfunction

  function automatic logic [CH*128-1:0] rand_img();
    logic [CH*128-1:0] r;
    for (int i = 0; i < CH*16; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic logic [CH*72-1:0] fill_kernel(input logic [7:0] v);
    logic [CH*72-1:0] r;
    for (int i = 0; i < CH*9; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  // Memory responder and write sink, both acting on the falling edge.
  always @(negedge clk) begin
    if (active) begin
      if (done) dones++;
      if (in_re) begin
        checkOutput("in_addr", in_addr, exp_in_addr);
        pend_addr = exp_in_addr;
        exp_in_addr++;
        pend = 1'b1;
        pend_cnt = (pend_addr == delay_addr) ? delay_len : 0;
        in_valid = 1'b0;
        image = '1;
      end else if (pend && pend_cnt == 0) begin
        in_valid = 1'b1;
        image = img_tab[pend_addr % NOUT];
        sb.push_back('{pend_addr[AW-1:0], model(img_tab[pend_addr % NOUT])});
        pend = 1'b0;
      end else begin
        if (pend) pend_cnt--;
        in_valid = 1'b0;
        image = '1;
      end
      if (out_we) begin
        checkOutput("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          checkOutput("out_addr", out_addr, sb[0].addr);
          checkOutput("y", y, sb[0].y);
          if (out_addr == stall_addr && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
            void'(sb.pop_front());
            writes++;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic applyStimulus(input string name, input bit check_timing, input bit restart_mid);
    int done_n;
    @(negedge clk);
    exp_in_addr = 0;
    writes = 0;
    dones = 0;
    pend = 1'b0;
    stall_left = stall_len;
    sb.delete();
    active = 1'b1;
    kernel = cfg_kernel;
    bias = cfg_bias[BW-1:0];
    pool_mode = cfg_mode;
    start = 1'b1;
    done_n = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) checkOutput({name, "_busy_rise"}, busy, 1);
      if (restart_mid && n == 6) begin
        start = 1'b1;
        kernel = ~cfg_kernel;
        pool_mode = ~cfg_mode;
        bias = ~bias;
      end
      if (done) begin
        done_n = n;
        break;
      end
    end
    checkOutput({name, "_done_seen"}, (done_n != 0), 1);
    if (check_timing) checkOutput({name, "_latency"}, done_n, 17);
    checkOutput({name, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    checkOutput({name, "_done_pulse"}, done, 0);
    checkOutput({name, "_done_count"}, dones, 1);
    checkOutput({name, "_writes"}, writes, NOUT);
    checkOutput({name, "_reads"}, exp_in_addr, NOUT);
    checkOutput({name, "_sb_left"}, sb.size(), 0);
    active = 1'b0;
  endtask

  initial begin
    int got2;
    rst = 1'b1; start = 1'b0; pool_mode = 1'b0; bias = '0; kernel = '0;
    image = '0; in_valid = 1'b0; out_ready = 1'b0;
    delay_addr = -1; delay_len = 0; stall_addr = -1; stall_len = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_re", in_re, 0);
    checkOutput("rst_out_we", out_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_y", y, 0);
    checkOutput("rst_addr", in_addr, 0);
    rst = 1'b0;

    // Saturating high: every conv output is 270.
    for (int i = 0; i < NOUT; i++)
      for (int p = 0; p < CH*16; p++) img_tab[i][p*8 +: 8] = 8'd10;
    cfg_kernel = fill_kernel(8'h01); cfg_bias = 0; cfg_mode = 1'b0;
    applyStimulus("sat_avg", 1'b1, 1'b0);
    cfg_mode = 1'b1;
    applyStimulus("sat_max", 1'b1, 1'b0);

    // Saturating low.
    cfg_kernel = fill_kernel(8'hFF); cfg_mode = 1'b0;
    applyStimulus("neg_avg", 1'b0, 1'b0);
    cfg_mode = 1'b1;
    applyStimulus("neg_max", 1'b0, 1'b0);

    // Single coefficient picks out p[0][0..1] and p[1][0..1] of channel 0.
    for (int i = 0; i < NOUT; i++) img_tab[i] = rand_img();
    for (int p = 0; p < 16; p++) img_tab[0][p*8 +: 8] = 8'd0;
    img_tab[0][0 +: 8] = 8'd4;
    img_tab[0][8 +: 8] = 8'd8;
    img_tab[0][32 +: 8] = 8'd12;
    img_tab[0][40 +: 8] = 8'd20;
    cfg_kernel = '0; cfg_kernel[7:0] = 8'd1;
    cfg_bias = 0; cfg_mode = 1'b0;
    applyStimulus("one_avg", 1'b0, 1'b0);
    cfg_mode = 1'b1;
    applyStimulus("one_max", 1'b0, 1'b0);
    cfg_bias = -5; cfg_mode = 1'b0;
    applyStimulus("bias_avg", 1'b0, 1'b0);
    cfg_mode = 1'b1;
    applyStimulus("bias_max", 1'b0, 1'b0);

    // Random mid-range data with read latency, write stall and an ignored start.
    delay_addr = 1; delay_len = 3; stall_addr = 2; stall_len = 5;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NOUT; i++) img_tab[i] = rand_img();
      for (int i = 0; i < CH*9; i++) cfg_kernel[i*8 +: 8] = 8'($urandom_range(0, 8) - 4);
      cfg_bias = int'($urandom_range(0, 600)) - 300;
      cfg_mode = m[0];
      applyStimulus(m == 0 ? "stall_avg" : "stall_max", 1'b0, 1'b1);
    end

    // Abort while waiting on address 2, then confirm a clean restart.
    delay_addr = 2; delay_len = 30; stall_addr = -1; stall_len = 0;
    @(negedge clk);
    exp_in_addr = 0; writes = 0; dones = 0; pend = 1'b0; sb.delete(); active = 1'b1;
    kernel = cfg_kernel; bias = cfg_bias[BW-1:0]; pool_mode = cfg_mode; start = 1'b1;
    got2 = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (in_re && in_addr == 16'd2) begin
        got2 = 1;
        break;
      end
    end
    checkOutput("abort_reached_addr2", got2, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_in_re", in_re, 0);
    checkOutput("abort_out_we", out_we, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_y", y, 0);
    checkOutput("abort_addr", out_addr, 0);
    rst = 1'b0;
    active = 1'b0;
    pend = 1'b0;
    delay_addr = -1; delay_len = 0;
    applyStimulus("restart", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_pool_stream.md
Name: conv_pool_stream

Overview:
- Parametrised successor to the fixed 3-channel conv/clamp/pool engine.
- Per output pixel it:
  - fetches one 4x4 window per channel from input memory;
  - applies a 3x3 signed kernel per channel (valid convolution, 2x2 result);
  - sums across channels, adds a per-layer bias and clamps to [0,255];
  - pools the 2x2 result by average or max and writes one 8-bit result.
- Adds start/done control, variable read latency (in_valid) and write back-pressure (out_ready).

Parameters:
- CHANNELS, 3: number of input channels (1..8).
- NUM_OUT, 65025: output pixels per run (1..2^ADDR_W).
- ADDR_W, 16: input/output address width.
- BIAS_W, 12: signed bias width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  one-cycle pulse that starts a run. Ignored unless idle.
- pool_mode  in  1  0 = average pool, 1 = max pool. Latched at start.
- bias  in  BIAS_W  signed bias added to every 2x2 conv sum. Latched at start.
- kernel  in  CHANNELS*72  per-channel 3x3 signed 8-bit coefficients. Latched at start.
- image  in  CHANNELS*128  per-channel 4x4 unsigned 8-bit pixels.
- in_valid  in  1  image data valid.
- in_re  out  1  input read strobe.
- in_addr  out  ADDR_W  input window address.
- out_ready  in  1  sink accepts the write.
- out_we  out  1  output write strobe.
- out_addr  out  ADDR_W  output address.
- y  out  8  pooled result.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset: all outputs 0, counter 0, state IDLE, latched config 0.
- Reset applies from any state and takes priority over all other inputs.
- Bit packing:
  - channel c occupies image[c*128 +:128] and kernel[c*72 +:72];
  - pixel p[r][col] = bits [(r*4+col)*8 +:8];
  - coefficient k[i][j] = bits [(i*3+j)*8 +:8], signed.
- Conv: o[a][b] = sum over c,i,j of k_c[i][j]*p_c[a+i][b+j] + bias, for a,b in {0,1}. Full-precision signed arithmetic, no overflow at any width.
- Clamp: o<=0 gives 0; o>=255 gives 255; otherwise o.
- Pool: average = floor(sum of the four clamped values / 4); max = largest of the four.
- FSM:
  - IDLE: on start, latch config, counter=0, busy=1, go to FETCH.
  - FETCH: in_re=1 and in_addr=counter for exactly one cycle, then WAIT.
  - WAIT: in_re=0. Capture image in the cycle in_valid=1, then CALC. in_valid outside WAIT is ignored.
  - CALC: one registered pipeline stage (conv/clamp/pool result), then WRITE.
  - WRITE: out_we=1, out_addr=counter, y=result.
    - All three hold stable while out_ready=0.
    - In the cycle out_we and out_ready are both 1, the write is accepted.
    - After acceptance: if counter==NUM_OUT-1, go to DONE; else counter+1 and go to FETCH. out_we falls the next cycle.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Throughput: 4 cycles per output when in_valid comes one cycle after in_re and out_ready is held high.
- Start while busy: ignored. Latched config stays unchanged through the run.
- NUM_OUT=1: a single write, then DONE.
- The counter never wraps past NUM_OUT-1.
- Rst mid-run: abort. No further in_re or out_we; next cycle is IDLE.

Test Plan:
- CHANNELS=3, all pixels 10, all kernels +1, bias 0, avg -> each o=270 clamps to 255, y=255. Repeat with max -> y=255.
- All kernels -1 -> all o negative, y=0 in both modes.
- Only kernel_0 k[0][0]=1 (rest 0), image_0 with p[0][0]=4, p[0][1]=8, p[1][0]=12, p[1][1]=20, bias 0 -> avg y=11, max y=20.
- Same data with bias=-5 -> clamped 0,3,7,15 -> avg y=6, max y=15.
- NUM_OUT=4, in_valid delayed 3 cycles on address 1, out_ready low 5 cycles on address 2:
  - in_addr sequence 0,1,2,3; out_addr 0..3, each written exactly once;
  - out_we/out_addr/y held during the stall;
  - done pulses once; second start during the run ignored.
- Rst asserted during WAIT of address 2 -> next cycle all outputs 0 and busy=0. A new start restarts at in_addr 0.
